// File: rtl/magnitude_estimator_if.sv
// Sample/result handshake bundle for the magnitude estimator.
// The producer/consumer side uses master; the estimator itself uses slave.
interface magnitude_estimator_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] InputReal;
    logic [WIDTH-1:0] InputImaginary;
    logic             InputMode;
    logic             InValid;
    logic             InReady;
    logic [WIDTH:0]   OutputAnswer;
    logic             OutValid;
    logic             OutReady;
    logic             Busy;

    modport master (
        output InputReal,
        output InputImaginary,
        output InputMode,
        output InValid,
        output OutReady,
        input  InReady,
        input  OutputAnswer,
        input  OutValid,
        input  Busy
    );

    modport slave (
        input  InputReal,
        input  InputImaginary,
        input  InputMode,
        input  InValid,
        input  OutReady,
        output InReady,
        output OutputAnswer,
        output OutValid,
        output Busy
    );
endinterface

// File: rtl/magnitude_estimator.sv
// Iterative |Real + j*Imag| estimator: binomial Max + Min^2/(2*Max) via a restoring
// divider, or exact floor(sqrt(Real^2 + Imag^2)) via a non-restoring digit-by-digit root.
module magnitude_estimator #(
    parameter int WIDTH      = 8,
    parameter int ITER_EXACT = WIDTH + 1
) (
    input logic                SqrtClock,
    input logic                SqrtResetN,
    magnitude_estimator_if.slave bus
);

    localparam int CW = $clog2(ITER_EXACT + 1);
    localparam int DW = 2 * ITER_EXACT;
    localparam int RW = ITER_EXACT + 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        ROOT,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    logic                 readyArmed;
    logic [WIDTH-1:0]     latReal;
    logic [WIDTH-1:0]     latImag;
    logic                 latMode;
    logic [WIDTH-1:0]     maxVal;
    logic [WIDTH-1:0]     minVal;
    logic                 loadPhase;
    logic [CW-1:0]        iterCount;

    logic [WIDTH:0]       divisor;
    logic [WIDTH:0]       divRem;
    logic [WIDTH-1:0]     divLow;
    logic [WIDTH-1:0]     quotient;

    logic [DW-1:0]        radicand;
    logic signed [RW-1:0] rootRem;
    logic [ITER_EXACT-1:0] rootQ;

    logic [WIDTH:0]       result;

    logic                 accept;
    logic                 lastIter;
    logic [2*WIDTH-1:0]   minSq;
    logic [2*WIDTH-1:0]   maxSq;
    logic [2*WIDTH:0]     sumSq;

    logic [WIDTH+1:0]     divShift;
    logic                 qBit;
    logic [WIDTH:0]       divRemNext;
    logic [WIDTH-1:0]     quotNext;

    logic [1:0]           pair;
    logic signed [RW-1:0] remShift;
    logic signed [RW-1:0] rootRemNext;
    logic [ITER_EXACT-1:0] rootQNext;

    assign accept   = bus.InValid && bus.InReady;
    assign lastIter = (iterCount == CW'(1));

    assign minSq = {{WIDTH{1'b0}}, minVal} * {{WIDTH{1'b0}}, minVal};
    assign maxSq = {{WIDTH{1'b0}}, maxVal} * {{WIDTH{1'b0}}, maxVal};
    assign sumSq = {1'b0, maxSq} + {1'b0, minSq};

    // Min^2 < 2*Max * 2^WIDTH, so the upper half of the dividend is already below
    // the divisor and only WIDTH shift/subtract steps are needed. A zero divisor
    // (Max = 0) must never produce a quotient bit.
    assign divShift   = {divRem, divLow[WIDTH-1]};
    assign qBit       = (divisor != '0) && (divShift >= {1'b0, divisor});
    assign divRemNext = qBit ? (WIDTH+1)'(divShift - {1'b0, divisor}) : divShift[WIDTH:0];
    assign quotNext   = {quotient[WIDTH-2:0], qBit};

    // Non-restoring root: subtract 4Q+1 after a non-negative remainder, add 4Q+3
    // after a negative one; the result bit is the sign of the new remainder.
    assign pair        = radicand[DW-1 -: 2];
    assign remShift    = (rootRem <<< 2) + signed'({{(RW-2){1'b0}}, pair});
    assign rootRemNext = rootRem[RW-1] ? remShift + signed'({2'b00, rootQ, 2'b11})
                                       : remShift - signed'({2'b00, rootQ, 2'b01});
    assign rootQNext   = {rootQ[ITER_EXACT-2:0], ~rootRemNext[RW-1]};

    always_ff @(posedge SqrtClock or negedge SqrtResetN) begin
        if (!SqrtResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = LOAD;
            LOAD: if (loadPhase) stateNext = latMode ? ROOT : DIV;
            DIV:  if (lastIter) stateNext = DONE;
            ROOT: if (lastIter) stateNext = DONE;
            DONE: if (bus.OutReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge SqrtClock or negedge SqrtResetN) begin
        if (!SqrtResetN) begin
            readyArmed <= 1'b0;
            latReal    <= '0;
            latImag    <= '0;
            latMode    <= 1'b0;
            maxVal     <= '0;
            minVal     <= '0;
            loadPhase  <= 1'b0;
            iterCount  <= '0;
            divisor    <= '0;
            divRem     <= '0;
            divLow     <= '0;
            quotient   <= '0;
            radicand   <= '0;
            rootRem    <= '0;
            rootQ      <= '0;
            result     <= '0;
        end else begin
            readyArmed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        latReal <= bus.InputReal;
                        latImag <= bus.InputImaginary;
                        latMode <= bus.InputMode;
                    end
                end
                // LOAD spends one cycle ordering the components and one cycle
                // registering the squares, keeping the multipliers off the iteration path.
                LOAD: begin
                    if (!loadPhase) begin
                        loadPhase <= 1'b1;
                        if (latImag > latReal) begin
                            maxVal <= latImag;
                            minVal <= latReal;
                        end else begin
                            maxVal <= latReal;
                            minVal <= latImag;
                        end
                    end else begin
                        loadPhase <= 1'b0;
                        if (latMode) begin
                            iterCount <= CW'(ITER_EXACT);
                            radicand  <= DW'(sumSq);
                            rootRem   <= '0;
                            rootQ     <= '0;
                        end else begin
                            iterCount <= CW'(WIDTH);
                            divisor   <= {maxVal, 1'b0};
                            divRem    <= {1'b0, minSq[2*WIDTH-1:WIDTH]};
                            divLow    <= minSq[WIDTH-1:0];
                            quotient  <= '0;
                        end
                    end
                end
                DIV: begin
                    divRem    <= divRemNext;
                    divLow    <= divLow << 1;
                    quotient  <= quotNext;
                    iterCount <= iterCount - CW'(1);
                    if (lastIter) result <= {1'b0, maxVal} + {1'b0, quotNext};
                end
                ROOT: begin
                    rootRem   <= rootRemNext;
                    rootQ     <= rootQNext;
                    radicand  <= radicand << 2;
                    iterCount <= iterCount - CW'(1);
                    if (lastIter) result <= (WIDTH+1)'(rootQNext);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.InReady      = (state == IDLE) && readyArmed;
    assign bus.Busy         = (state != IDLE);
    assign bus.OutValid     = (state == DONE);
    assign bus.OutputAnswer = (state == DONE) ? result : '0;

endmodule

// File: tb/tb_magnitude_estimator.sv
// Directed bench for magnitude_estimator at WIDTH=8: values, latency, backpressure,
// reset recovery and input isolation.
module tb_magnitude_estimator;

    logic SqrtClock = 1'b0;
    logic SqrtResetN = 1'b0;
    int   passCount = 0;
    int   totalCount = 0;

    magnitude_estimator_if #(.WIDTH(8)) bus ();

    magnitude_estimator #(.WIDTH(8)) dut (
        .SqrtClock (SqrtClock),
        .SqrtResetN(SqrtResetN),
        .bus       (bus)
    );

    always #5 SqrtClock = ~SqrtClock;

    task automatic waitReady();
        for (int w = 0; w < 50 && bus.InReady !== 1'b1; w++) begin
            @(posedge SqrtClock); #1;
        end
    endtask

    // Offers one sample and waits (bounded) for the result; edges = -1 on timeout.
    task automatic runSample(input logic [7:0] re, input logic [7:0] im, input logic md,
                             input bit scramble, output logic [8:0] ans, output int edges,
                             output bit zeroViol);
        edges = -1;
        ans = 'x;
        zeroViol = 1'b0;
        waitReady();
        bus.InputReal = re;
        bus.InputImaginary = im;
        bus.InputMode = md;
        bus.InValid = 1'b1;
        @(posedge SqrtClock); #1;
        bus.InValid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (scramble) begin
                bus.InputReal = 8'($urandom_range(0, 255));
                bus.InputImaginary = 8'($urandom_range(0, 255));
                bus.InputMode = 1'($urandom_range(0, 1));
            end
            @(posedge SqrtClock); #1;
            if (bus.OutValid === 1'b1) begin
                edges = n;
                ans = bus.OutputAnswer;
                break;
            end
            if (bus.OutputAnswer !== 9'd0) zeroViol = 1'b1;
        end
    endtask

    task automatic consume();
        bus.OutReady = 1'b1;
        @(posedge SqrtClock); #1;
        bus.OutReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge SqrtClock);
        #1;
        totalCount++; if (bus.OutValid !== 1'b0) $display("FAIL rst_outvalid: got %b want 0", bus.OutValid); else passCount++;
        totalCount++; if (bus.OutputAnswer !== 9'd0) $display("FAIL rst_answer: got %0d want 0", bus.OutputAnswer); else passCount++;
        totalCount++; if (bus.Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.Busy); else passCount++;
        totalCount++; if (bus.InReady !== 1'b0) $display("FAIL rst_inready: got %b want 0", bus.InReady); else passCount++;
        @(negedge SqrtClock);
        SqrtResetN = 1'b1;
        #1;
        totalCount++; if (bus.InReady !== 1'b0) $display("FAIL rst_release_inready: got %b want 0", bus.InReady); else passCount++;
        @(posedge SqrtClock); #1;
        totalCount++; if (bus.InReady !== 1'b1) $display("FAIL rst_first_edge_inready: got %b want 1", bus.InReady); else passCount++;
    endtask

    task automatic test_binomial();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd3, 8'd4, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd5) $display("FAIL binom_3_4_value: got %0d want 5", ans); else passCount++;
        totalCount++; if (edges != 10) $display("FAIL binom_3_4_latency: got %0d want 10", edges); else passCount++;
        totalCount++; if (zv) $display("FAIL binom_answer_zero_when_invalid: got nonzero want 0"); else passCount++;
        consume();
    endtask

    task automatic test_exact();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd3, 8'd4, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd5) $display("FAIL exact_3_4_value: got %0d want 5", ans); else passCount++;
        totalCount++; if (edges != 11) $display("FAIL exact_3_4_latency: got %0d want 11", edges); else passCount++;
        consume();
        runSample(8'd255, 8'd255, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd360) $display("FAIL exact_255_255_value: got %0d want 360", ans); else passCount++;
        totalCount++; if (zv) $display("FAIL exact_answer_zero_when_invalid: got nonzero want 0"); else passCount++;
        consume();
        runSample(8'd200, 8'd9, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd200) $display("FAIL exact_200_9_value: got %0d want 200", ans); else passCount++;
        consume();
        runSample(8'd0, 8'd0, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd0) $display("FAIL exact_0_0_value: got %0d want 0", ans); else passCount++;
        consume();
    endtask

    task automatic test_extremes();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd255, 8'd255, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd382) $display("FAIL binom_255_255_value: got %0d want 382", ans); else passCount++;
        consume();
        runSample(8'd0, 8'd0, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd0) $display("FAIL binom_0_0_value: got %0d want 0", ans); else passCount++;
        totalCount++; if (edges != 10) $display("FAIL binom_0_0_latency: got %0d want 10", edges); else passCount++;
        consume();
        runSample(8'd0, 8'd7, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd7) $display("FAIL binom_0_7_value: got %0d want 7", ans); else passCount++;
        consume();
        runSample(8'd5, 8'd5, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd7) $display("FAIL binom_5_5_value: got %0d want 7", ans); else passCount++;
        consume();
        runSample(8'd100, 8'd60, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd118) $display("FAIL binom_100_60_value: got %0d want 118", ans); else passCount++;
        consume();
    endtask

    task automatic test_backpressure();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd4, 8'd3, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd5) $display("FAIL bp_value: got %0d want 5", ans); else passCount++;
        for (int c = 0; c < 5; c++) begin
            @(posedge SqrtClock); #1;
            totalCount++; if (bus.OutputAnswer !== 9'd5) $display("FAIL bp_hold_answer: got %0d want 5", bus.OutputAnswer); else passCount++;
            totalCount++; if (bus.OutValid !== 1'b1) $display("FAIL bp_hold_outvalid: got %b want 1", bus.OutValid); else passCount++;
            totalCount++; if (bus.InReady !== 1'b0) $display("FAIL bp_hold_inready: got %b want 0", bus.InReady); else passCount++;
        end
        bus.OutReady = 1'b1;
        bus.InValid = 1'b1;
        #1;
        totalCount++; if (bus.InReady !== 1'b0) $display("FAIL bp_consume_cycle_inready: got %b want 0", bus.InReady); else passCount++;
        @(posedge SqrtClock); #1;
        bus.OutReady = 1'b0;
        bus.InValid = 1'b0;
        totalCount++; if (bus.InReady !== 1'b1) $display("FAIL bp_release_inready: got %b want 1", bus.InReady); else passCount++;
        totalCount++; if (bus.OutValid !== 1'b0) $display("FAIL bp_release_outvalid: got %b want 0", bus.OutValid); else passCount++;
        totalCount++; if (bus.OutputAnswer !== 9'd0) $display("FAIL bp_release_answer: got %0d want 0", bus.OutputAnswer); else passCount++;
        totalCount++; if (bus.Busy !== 1'b0) $display("FAIL bp_release_busy: got %b want 0", bus.Busy); else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd12, 8'd5, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd13) $display("FAIL b2b_first_value: got %0d want 13", ans); else passCount++;
        consume();
        runSample(8'd8, 8'd6, 1'b0, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd10) $display("FAIL b2b_second_value: got %0d want 10", ans); else passCount++;
        totalCount++; if (edges != 10) $display("FAIL b2b_second_latency: got %0d want 10", edges); else passCount++;
        consume();
    endtask

    task automatic test_reset_mid();
        logic [8:0] ans; int edges; bit zv; bit sawValid;
        waitReady();
        bus.InputReal = 8'd255;
        bus.InputImaginary = 8'd255;
        bus.InputMode = 1'b1;
        bus.InValid = 1'b1;
        @(posedge SqrtClock); #1;
        bus.InValid = 1'b0;
        repeat (5) @(posedge SqrtClock);
        #1;
        totalCount++; if (bus.Busy !== 1'b1) $display("FAIL mid_busy_before_reset: got %b want 1", bus.Busy); else passCount++;
        #2;
        SqrtResetN = 1'b0;
        #1;
        totalCount++; if (bus.OutValid !== 1'b0) $display("FAIL mid_rst_outvalid: got %b want 0", bus.OutValid); else passCount++;
        totalCount++; if (bus.OutputAnswer !== 9'd0) $display("FAIL mid_rst_answer: got %0d want 0", bus.OutputAnswer); else passCount++;
        totalCount++; if (bus.Busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.Busy); else passCount++;
        totalCount++; if (bus.InReady !== 1'b0) $display("FAIL mid_rst_inready: got %b want 0", bus.InReady); else passCount++;
        @(posedge SqrtClock); #2;
        SqrtResetN = 1'b1;
        sawValid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge SqrtClock); #1;
            if (bus.OutValid !== 1'b0) sawValid = 1'b1;
        end
        totalCount++; if (sawValid) $display("FAIL mid_no_stale_outvalid: got 1 want 0"); else passCount++;
        totalCount++; if (bus.InReady !== 1'b1) $display("FAIL mid_inready_after_release: got %b want 1", bus.InReady); else passCount++;
        runSample(8'd3, 8'd4, 1'b1, 1'b0, ans, edges, zv);
        totalCount++; if (ans !== 9'd5) $display("FAIL mid_new_sample_value: got %0d want 5", ans); else passCount++;
        consume();
    endtask

    task automatic test_isolation();
        logic [8:0] ans; int edges; bit zv;
        runSample(8'd255, 8'd255, 1'b1, 1'b1, ans, edges, zv);
        totalCount++; if (ans !== 9'd360) $display("FAIL iso_exact_value: got %0d want 360", ans); else passCount++;
        totalCount++; if (edges != 11) $display("FAIL iso_exact_latency: got %0d want 11", edges); else passCount++;
        consume();
        runSample(8'd3, 8'd4, 1'b0, 1'b1, ans, edges, zv);
        totalCount++; if (ans !== 9'd5) $display("FAIL iso_binom_value: got %0d want 5", ans); else passCount++;
        totalCount++; if (edges != 10) $display("FAIL iso_binom_latency: got %0d want 10", edges); else passCount++;
        consume();
    endtask

    initial begin
        bus.InputReal = '0;
        bus.InputImaginary = '0;
        bus.InputMode = 1'b0;
        bus.InValid = 1'b0;
        bus.OutReady = 1'b0;
        test_reset();
        test_binomial();
        test_exact();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_isolation();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/magnitude_estimator.md
MAGNITUDE_ESTIMATOR -- requirements
Module: magnitude_estimator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of each input component (unsigned).
REQ-002 SHALL have parameter ITER_EXACT, default WIDTH+1, giving the iteration count of the exact-root engine; fixed, not user-tunable.
REQ-003 SqrtClock  input  1  single clock; all state updates on its rising edge.
REQ-004 SqrtResetN  input  1  asynchronous, active-low reset.
REQ-005 InputReal  input  WIDTH  unsigned real-component magnitude.
REQ-006 InputImaginary  input  WIDTH  unsigned imaginary-component magnitude.
REQ-007 InputMode  input  1  0 = binomial approximation, 1 = exact integer root.
REQ-008 InValid  input  1  input sample present.
REQ-009 InReady  output  1  block can accept a sample.
REQ-010 OutputAnswer  output  WIDTH+1  magnitude result.
REQ-011 OutValid  output  1  OutputAnswer valid.
REQ-012 OutReady  input  1  downstream accepts the result.
REQ-013 Busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DIV, ROOT and DONE.
REQ-015 SHALL accept a sample on an edge where InValid=1 and InReady=1.
REQ-016 InReady SHALL be 1 only in IDLE.
REQ-017 On accept, SHALL latch InputReal, InputImaginary and InputMode; later input changes SHALL have no effect on the sample in flight.
REQ-018 LOAD SHALL set Max = larger and Min = smaller of the latched components (equal: Max = Real), set the iteration counter, and select the next state from the latched mode.
REQ-019 Binomial mode SHALL compute Max + floor(Min*Min / (2*Max)).
REQ-020 The Min*Min term SHALL be 2*WIDTH bits, the 2*Max divisor WIDTH+1 bits, and the quotient SHALL fit WIDTH bits.
REQ-021 Binomial mode SHALL use a restoring divider in DIV, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-022 Binomial mode with Max=0 SHALL yield 0 with no division fault, while still spending the full WIDTH DIV cycles.
REQ-023 Exact mode SHALL compute floor(sqrt(Real^2 + Imag^2)) on a 2*WIDTH+1-bit radicand.
REQ-024 Exact mode SHALL use a digit-by-digit (non-restoring) root in ROOT, one result bit per cycle, for exactly ITER_EXACT cycles.
REQ-025 Latency SHALL be data-independent: OutValid rises WIDTH+2 edges after the accept edge in binomial mode and WIDTH+3 edges in exact mode.
REQ-026 In DONE, OutValid SHALL be 1 and OutputAnswer SHALL be held stable until an edge with OutReady=1, after which the FSM returns to IDLE.
REQ-027 SHALL accept no new sample in the cycle the result is consumed; the earliest new accept is the following edge.
REQ-028 OutputAnswer SHALL NOT overflow: the binomial result is at most 1.5*(2^WIDTH-1) and the exact result at most sqrt(2)*(2^WIDTH-1), both within WIDTH+1 bits.
REQ-029 OutputAnswer SHALL be 0 whenever OutValid=0.

Reset
REQ-030 Assertion of SqrtResetN=0 SHALL immediately force IDLE, OutValid=0, OutputAnswer=0, Busy=0 and InReady=0, and SHALL clear all data registers and counters.
REQ-031 InReady SHALL rise on the first edge after SqrtResetN deasserts.
REQ-032 Reset during LOAD, DIV, ROOT or DONE SHALL discard the sample in flight; no OutValid pulse SHALL follow deassertion without a new accept.

Verification (WIDTH=8)
REQ-033 Binomial timing and value: mode 0, Real=3, Imag=4 -> OutputAnswer=5 with OutValid rising exactly 10 edges after accept.
REQ-034 Exact timing and value: mode 1, Real=3, Imag=4 -> 5 after 11 edges; mode 1, Real=255, Imag=255 -> 360.
REQ-035 Binomial extremes: mode 0, Real=255, Imag=255 -> 382; Real=0, Imag=0 -> 0; Real=0, Imag=7 -> 7, with no X values on the output.
REQ-036 Backpressure: hold OutReady=0 for 5 cycles in DONE -> OutputAnswer and OutValid stable and InReady=0 throughout; release -> IDLE and InReady=1 next edge.
REQ-037 Reset mid-operation: assert SqrtResetN=0 during cycle 4 of ROOT -> outputs 0 immediately; after release no OutValid appears until a new accept, and a new 3/4 sample -> 5.
REQ-038 Input isolation: change InputReal, InputImaginary and InputMode every cycle after accept -> result matches the latched sample.
